// File: rtl/thirty_two_bit_adder_pipe.sv
// 32-bit two's-complement adder: four 8-bit CLA blocks under a second-level lookahead unit.
// ADDER_OUTPUT_REG_EN selects registered outputs (1-cycle latency); undefined gives a purely combinational adder.
module thirty_two_bit_adder_pipe (
  output logic        overflow,
  output logic [31:0] S,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Cin,
  input  logic        clock,
  input  logic        reset_n
);

  // Carries c0..c7 of one 8-bit block, each expanded as a full sum of products (no ripple).
  function automatic logic [7:0] f_carries(input logic [7:0] g, input logic [7:0] p, input logic cin);
    logic [7:0] c;
    logic       term;
    c    = '0;
    c[0] = cin;
    for (int k = 1; k < 8; k++) begin
      term = cin;
      for (int j = 0; j < k; j++) term = term & p[j];
      c[k] = term;
      for (int j = 0; j < k; j++) begin
        term = g[j];
        for (int m = j + 1; m < k; m++) term = term & p[m];
        c[k] = c[k] | term;
      end
    end
    return c;
  endfunction

  function automatic logic f_blk_gen(input logic [7:0] g, input logic [7:0] p);
    logic gen;
    logic term;
    gen = 1'b0;
    for (int j = 0; j < 8; j++) begin
      term = g[j];
      for (int m = j + 1; m < 8; m++) term = term & p[m];
      gen = gen | term;
    end
    return gen;
  endfunction

  logic [31:0] w_g;
  logic [31:0] w_p;
  logic [31:0] w_carry;
  logic [3:0]  w_blk_g;
  logic [3:0]  w_blk_p;
  logic [3:0]  w_blk_cin;
  logic        w_c32;
  logic [31:0] w_sum;
  logic        w_ovf;

  assign w_g = A & B;
  assign w_p = A | B;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cla8
      assign w_blk_g[gi]          = f_blk_gen(w_g[gi*8 +: 8], w_p[gi*8 +: 8]);
      assign w_blk_p[gi]          = &w_p[gi*8 +: 8];
      assign w_carry[gi*8 +: 8]   = f_carries(w_g[gi*8 +: 8], w_p[gi*8 +: 8], w_blk_cin[gi]);
    end
  endgenerate

  // Second level: every block carry-in comes straight from block G/P and Cin.
  assign w_blk_cin[0] = Cin;
  assign w_blk_cin[1] = w_blk_g[0] | (w_blk_p[0] & Cin);
  assign w_blk_cin[2] = w_blk_g[1] | (w_blk_p[1] & w_blk_g[0]) | (w_blk_p[1] & w_blk_p[0] & Cin);
  assign w_blk_cin[3] = w_blk_g[2] | (w_blk_p[2] & w_blk_g[1]) | (w_blk_p[2] & w_blk_p[1] & w_blk_g[0])
                      | (w_blk_p[2] & w_blk_p[1] & w_blk_p[0] & Cin);
  assign w_c32        = w_blk_g[3] | (w_blk_p[3] & w_blk_g[2]) | (w_blk_p[3] & w_blk_p[2] & w_blk_g[1])
                      | (w_blk_p[3] & w_blk_p[2] & w_blk_p[1] & w_blk_g[0])
                      | (w_blk_p[3] & w_blk_p[2] & w_blk_p[1] & w_blk_p[0] & Cin);

  assign w_sum = A ^ B ^ w_carry;
  assign w_ovf = w_carry[31] ^ w_c32;

`ifdef ADDER_OUTPUT_REG_EN
  logic [31:0] r_s;
  logic        r_ovf;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_s   <= 32'h0000_0000;
      r_ovf <= 1'b0;
    end else begin
      r_s   <= w_sum;
      r_ovf <= w_ovf;
    end
  end

  assign S        = r_s;
  assign overflow = r_ovf;
`else
  // clock and reset_n are kept as ports so both builds share one footprint.
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clock & reset_n;

  assign S        = w_sum;
  assign overflow = w_ovf;
`endif

endmodule

// File: tb/tb_thirty_two_bit_adder_pipe.sv
// Directed bench for thirty_two_bit_adder_pipe; adapts timing expectations to ADDER_OUTPUT_REG_EN.
module tb_thirty_two_bit_adder_pipe;

  logic        overflow;
  logic [31:0] S;
  logic [31:0] A;
  logic [31:0] B;
  logic        Cin;
  logic        clock;
  logic        reset_n;

  int pass_cnt  = 0;
  int total_cnt = 0;

  thirty_two_bit_adder_pipe dut (
    .overflow (overflow),
    .S        (S),
    .A        (A),
    .B        (B),
    .Cin      (Cin),
    .clock    (clock),
    .reset_n  (reset_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  // Applies operands and waits until the result is due at the outputs.
  task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic cin);
`ifdef ADDER_OUTPUT_REG_EN
    @(negedge clock);
    A = a; B = b; Cin = cin;
    @(posedge clock);
    #1;
`else
    A = a; B = b; Cin = cin;
    #1;
`endif
  endtask

  task automatic test_reset();
    logic [31:0] exp_s;
    A = 32'h1; B = 32'h1; Cin = 1'b0; reset_n = 1'b0;
`ifdef ADDER_OUTPUT_REG_EN
    exp_s = 32'h0;
`else
    exp_s = 32'h2;
`endif
    repeat (2) @(posedge clock);
    #1;
    total_cnt++;
    if (S !== exp_s) $display("FAIL reset_s: got %h, required %h", S, exp_s);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== 1'b0) $display("FAIL reset_ovf: got %b, required 0", overflow);
    else pass_cnt++;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    total_cnt++;
    if (S !== 32'h2) $display("FAIL reset_first_edge: got %h, required 00000002", S);
    else pass_cnt++;
    $display("reset: S=%h overflow=%b", S, overflow);
  endtask

  task automatic test_vectors();
    logic [31:0] va [0:18] = '{32'h00000001, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h55555555,
                               32'h80000000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h00000005,
                               32'h00000000, 32'h000000FF, 32'h00FFFFFF, 32'h7FFFFFFF, 32'hFFFFFFFF,
                               32'h80000000, 32'h12345678, 32'h0000FFFF, 32'hFFFFFFFF};
    logic [31:0] vb [0:18] = '{32'h00000001, 32'h00000001, 32'h7FFFFFFF, 32'h80000000, 32'h55555555,
                               32'h7FFFFFFF, 32'h00000001, 32'hFFFFFFFE, 32'h80000000, 32'hFFFFFFFC,
                               32'h00000000, 32'h00000001, 32'h00000000, 32'h00000000, 32'hFFFFFFFF,
                               32'hFFFFFFFF, 32'h87654321, 32'h0000FFFF, 32'h00000000};
    logic        vc [0:18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] vs [0:18] = '{32'h00000002, 32'h80000000, 32'hFFFFFFFE, 32'h00000000, 32'hAAAAAAAA,
                               32'hFFFFFFFF, 32'h00000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000002,
                               32'h00000001, 32'h00000100, 32'h01000000, 32'h80000000, 32'hFFFFFFFF,
                               32'h7FFFFFFF, 32'h99999999, 32'h0001FFFE, 32'h00000000};
    logic        vo [0:18] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                               1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 19; i++) begin
      apply(va[i], vb[i], vc[i]);
      total_cnt++;
      if (S !== vs[i]) $display("FAIL vec%0d_s: %h+%h+%b got %h, required %h", i, va[i], vb[i], vc[i], S, vs[i]);
      else pass_cnt++;
      total_cnt++;
      if (overflow !== vo[i]) $display("FAIL vec%0d_ovf: got %b, required %b", i, overflow, vo[i]);
      else pass_cnt++;
      $display("vec%0d: %h + %h + %b -> S=%h overflow=%b", i, va[i], vb[i], vc[i], S, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] va [0:3] = '{32'h00000010, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'h0F0F0F0F};
    logic [31:0] vb [0:3] = '{32'h00000020, 32'h00000001, 32'h00000001, 32'h10101010};
    logic [31:0] vs [0:3] = '{32'h00000030, 32'h80000000, 32'h00000000, 32'h1F1F1F1F};
    logic        vo [0:3] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] prev_s;
    logic [31:0] exp_pre;
    apply(32'h00000003, 32'h00000004, 1'b0);
    total_cnt++;
    if (S !== 32'h7) $display("FAIL b2b_prime: got %h, required 00000007", S);
    else pass_cnt++;
    prev_s = 32'h7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      A = va[i]; B = vb[i]; Cin = 1'b0;
      #1;
`ifdef ADDER_OUTPUT_REG_EN
      exp_pre = prev_s;
`else
      exp_pre = vs[i];
`endif
      total_cnt++;
      if (S !== exp_pre) $display("FAIL b2b%0d_pre_edge: got %h, required %h", i, S, exp_pre);
      else pass_cnt++;
      @(posedge clock);
      #1;
      total_cnt++;
      if (S !== vs[i] || overflow !== vo[i])
        $display("FAIL b2b%0d: got %h/%b, required %h/%b", i, S, overflow, vs[i], vo[i]);
      else pass_cnt++;
      $display("b2b%0d: %h + %h -> S=%h overflow=%b", i, va[i], vb[i], S, overflow);
      prev_s = vs[i];
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp_s;
    logic        exp_o;
    apply(32'h7FFFFFFF, 32'h00000001, 1'b0);
    total_cnt++;
    if (S !== 32'h80000000 || overflow !== 1'b1)
      $display("FAIL arst_load: got %h/%b, required 80000000/1", S, overflow);
    else pass_cnt++;
    #2;
    reset_n = 1'b0;
    #1;
`ifdef ADDER_OUTPUT_REG_EN
    exp_s = 32'h0; exp_o = 1'b0;
`else
    exp_s = 32'h80000000; exp_o = 1'b1;
`endif
    total_cnt++;
    if (S !== exp_s) $display("FAIL arst_s: got %h, required %h", S, exp_s);
    else pass_cnt++;
    total_cnt++;
    if (overflow !== exp_o) $display("FAIL arst_ovf: got %b, required %b", overflow, exp_o);
    else pass_cnt++;
    A = 32'h10; B = 32'h20; Cin = 1'b1;
    @(posedge clock);
    #1;
`ifdef ADDER_OUTPUT_REG_EN
    exp_s = 32'h0;
`else
    exp_s = 32'h31;
`endif
    total_cnt++;
    if (S !== exp_s) $display("FAIL arst_held: got %h, required %h", S, exp_s);
    else pass_cnt++;
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    total_cnt++;
    if (S !== 32'h31 || overflow !== 1'b0)
      $display("FAIL arst_release: got %h/%b, required 00000031/0", S, overflow);
    else pass_cnt++;
    $display("async_reset: after release S=%h overflow=%b", S, overflow);
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
